// File: rtl/sum_bird_arbiter_if.sv
// ============================================================================
// Module      : sum_bird_arbiter_if
// Description : Request, adder and response signal bundle for sum_bird_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface sum_bird_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int CW   = 8
);
   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [W-1:0]      add_a;
   logic [W-1:0]      add_b;
   logic [W-1:0]      add_sum;
   logic              add_of;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [W-1:0]      rsp_sum;
   logic              rsp_of;
   logic [CW-1:0]     ovf_count;

   // master is the environment: requesters, response consumer and the adder
   modport master (
      output req_valid, req_a, req_b, rsp_ready, add_sum, add_of,
      input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_of, ovf_count
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, add_sum, add_of,
      output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_of, ovf_count
   );
endinterface

`default_nettype wire

// File: rtl/sum_bird_arbiter.sv
// ============================================================================
// Module      : sum_bird_arbiter
// Description : Round-robin sequencer sharing one sum_bird adder among NREQ
//               requesters, with registered results and overflow counting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sum_bird_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int CW   = 8
) (
   input  wire logic          clk,
   input  wire logic          reset_n,
   sum_bird_arbiter_if.slave  bus
);
   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IW-1:0]     r_last_grant;
   logic [IW-1:0]     w_grant_idx;
   logic [IW-1:0]     w_scan;
   logic              w_any;
   logic              w_accept;
   logic [NREQ-1:0]   w_grant_vec;
   logic [W-1:0]      r_op_a;
   logic [W-1:0]      r_op_b;
   logic [W-1:0]      r_rsp_sum;
   logic [IW-1:0]     r_rsp_id;
   logic              r_rsp_valid;
   logic              r_rsp_of;
   logic [CW-1:0]     r_ovf_count;

   // First valid requester strictly after the previous winner, wrapping.
   always_comb begin
      w_any       = 1'b0;
      w_grant_idx = '0;
      w_scan      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_scan = IW'((int'(r_last_grant) + k) % NREQ);
         if (!w_any && bus.req_valid[w_scan]) begin
            w_any       = 1'b1;
            w_grant_idx = w_scan;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_grant_vec = '0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_accept                 = 1'b1;
               w_grant_vec[w_grant_idx] = 1'b1;
               w_state_nxt              = S_EXEC;
            end
         end
         S_EXEC: w_state_nxt = S_RESP;
         S_RESP: begin
            if (r_rsp_valid && bus.rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= IW'(NREQ - 1);
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_rsp_id     <= '0;
         r_rsp_sum    <= '0;
         r_rsp_of     <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_ovf_count  <= '0;
      end else begin
         if (w_accept) begin
            r_op_a       <= bus.req_a[int'(w_grant_idx)*W +: W];
            r_op_b       <= bus.req_b[int'(w_grant_idx)*W +: W];
            r_rsp_id     <= w_grant_idx;
            r_last_grant <= w_grant_idx;
         end
         if (r_state == S_EXEC) begin
            r_rsp_sum   <= bus.add_sum;
            r_rsp_of    <= bus.add_of;
            r_rsp_valid <= 1'b1;
            // Counter sticks at all-ones rather than wrapping
            if (bus.add_of && (r_ovf_count != {CW{1'b1}})) begin
               r_ovf_count <= r_ovf_count + 1'b1;
            end
         end else if ((r_state == S_RESP) && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign bus.req_ready = w_grant_vec;
   assign bus.add_a     = r_op_a;
   assign bus.add_b     = r_op_b;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_sum   = r_rsp_sum;
   assign bus.rsp_of    = r_rsp_of;
   assign bus.ovf_count = r_ovf_count;

endmodule

`default_nettype wire
